// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side responder for the 6502 core bus
//
// Purpose: decodes the core's 16-bit address, returns registered read data
// and accepts writes into internal RAM (0x0000 .. 2^RAM_AW-1) and the vector
// page (FFFA-FFFF). After reset an internal sweep clears the RAM; the bus is
// served once the sweep finishes.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   resetn     in   1   asynchronous active-low reset
//   address    in   16  bus address from core
//   wr_en      in   1   write strobe, sampled on clk
//   wr_data    in   8   write data
//   rd_data    out  8   registered read data (1-clk latency, read-first)
//   ready      out  1   high once the RAM clear completes
//   bus_err    out  1   one-cycle pulse after an error access
//   err_count  out  8   saturating count of error accesses
//
// Configuration: define MEM_VEC_PROTECT_EN to make the vector page read-only
// (writes there are dropped and counted as errors).

module mem_responder #(
  parameter int          RAM_AW       = 11,
  parameter logic [15:0] NMI_VECTOR   = 16'h0200,
  parameter logic [15:0] RESET_VECTOR = 16'h0200,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0200,
  parameter logic [7:0]  OPEN_BUS     = 8'hFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        ready,
  output logic        bus_err,
  output logic [7:0]  err_count
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [16:0] RAM_SIZE = 17'd1 << RAM_AW;

`ifdef MEM_VEC_PROTECT_EN
  localparam logic VEC_WRITABLE = 1'b0;
`else
  localparam logic VEC_WRITABLE = 1'b1;
`endif

  logic [0:0]        state_q;
  logic [RAM_AW-1:0] clear_ptr;
  logic [7:0]        ram [0:(1<<RAM_AW)-1];
  logic [7:0]        vec_q [0:5];

  logic              in_ram;
  logic              in_vec;
  logic [2:0]        vec_idx;
  logic              err_now;
  logic [7:0]        rd_next;

  assign in_ram  = {1'b0, address} < RAM_SIZE;
  assign in_vec  = address >= 16'hFFFA;
  // FFFA..FFFF have low bits 010..111, so subtracting 2 maps them to 0..5
  assign vec_idx = address[2:0] - 3'd2;

  // Any write during the sweep, to unmapped space, or to a protected vector
  // page is an error; reads never are.
  assign err_now = wr_en && ((state_q == ST_CLEAR) ||
                             (!in_ram && !in_vec) ||
                             (in_vec && !VEC_WRITABLE));

  always_comb begin
    rd_next = OPEN_BUS;
    if (in_ram)      rd_next = ram[address[RAM_AW-1:0]];
    else if (in_vec) rd_next = vec_q[vec_idx];
  end

  assign ready = (state_q == ST_READY);

  // Clear sweep and read/write control
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_CLEAR;
      clear_ptr <= '0;
      rd_data   <= 8'h00;
      bus_err   <= 1'b0;
      err_count <= 8'h00;
    end else begin
      bus_err <= err_now;
      if (err_now && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (state_q == ST_CLEAR) begin
        rd_data   <= 8'h00;
        clear_ptr <= clear_ptr + 1'b1;
        if (&clear_ptr) state_q <= ST_READY;
      end else begin
        rd_data <= rd_next;
      end
    end
  end

  // RAM has no reset of its own; the sweep is what clears it.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR)
      ram[clear_ptr] <= 8'h00;
    else if (wr_en && in_ram)
      ram[address[RAM_AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vec_q[0] <= NMI_VECTOR[7:0];
      vec_q[1] <= NMI_VECTOR[15:8];
      vec_q[2] <= RESET_VECTOR[7:0];
      vec_q[3] <= RESET_VECTOR[15:8];
      vec_q[4] <= IRQ_VECTOR[7:0];
      vec_q[5] <= IRQ_VECTOR[15:8];
    end else if (state_q == ST_READY && wr_en && in_vec && VEC_WRITABLE) begin
      vec_q[vec_idx] <= wr_data;
    end
  end

endmodule
